// File: rtl/dpram_pkg.sv
// dpram_pkg: shared definitions for the byte-enable dual-port RAM.
//   - read-during-write mode codes for the RDW_MODE parameter
//   - lane_count(): number of byte lanes in a word
//   - clr_state_e: state encoding of the post-reset clear sequencer
package dpram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_DONE  = 1'b1
  } clr_state_e;

  function automatic int lane_count(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/dpram_clear_ctl.sv
// dpram_clear_ctl: post-reset memory-clear sequencer.
// Sweeps every address once, asserting clr_en_o with clr_addr_o so the parent
// writes zero there, then raises ready_o one edge after the last clear write.
// Ports:
//   clock_i     in   sole clock, rising edge
//   reset_i     in   asynchronous, active-high; restarts the sweep at 0
//   ready_o     out  high once the sweep is finished
//   clr_en_o    out  a clear write is due this cycle
//   clr_addr_o  out  address of that clear write
module dpram_clear_ctl
  import dpram_pkg::*;
#(
  parameter int ADDRWIDTH = 8,
  parameter bit DO_CLEAR  = 1'b1
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  output logic                 ready_o,
  output logic                 clr_en_o,
  output logic [ADDRWIDTH-1:0] clr_addr_o
);

  clr_state_e           state_q, state_d;
  logic [ADDRWIDTH-1:0] cnt_q, cnt_d;
  logic                 ready_q, ready_d;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= DO_CLEAR ? ST_CLEAR : ST_DONE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_en_o = 1'b0;
    // ready is a registered copy of "in DONE", so it rises one edge after
    // the final clear write (or one edge after reset when no clear is run).
    ready_d  = (state_q == ST_DONE);
    case (state_q)
      ST_CLEAR: begin
        clr_en_o = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_DONE;
      end
      default: ;
    endcase
  end

  assign ready_o    = ready_q;
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/dpram_be.sv
// dpram_be: true dual-port RAM, one clock, per-lane write enables.
// Features: selectable same-port read-during-write, optional output register,
// cross-port collision resolution (A wins per lane), post-reset zero fill.
// When MEM_INIT_FILE is set the zero fill is skipped so the implementation
// flow's memory initialisation is preserved.
// Ports:
//   clock, reset              clock and async active-high reset
//   ready                     ports accept requests
//   collision                 one-cycle pulse after a same-address dual write
//                             sharing at least one lane
//   address_x, data_x         port address / write data
//   wren_x, be_x              write request / lane enables
//   q_a, q_b                  read data
module dpram_be
  import dpram_pkg::*;
#(
  parameter int    DATAWIDTH      = 8,
  parameter int    ADDRWIDTH      = 8,
  parameter int    BYTEWIDTH      = 8,
  parameter int    RDW_MODE       = 0,
  parameter int    OUT_REG        = 0,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string MEM_INIT_FILE  = "",
  localparam int   LANES          = lane_count(DATAWIDTH, BYTEWIDTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 ready,
  output logic                 collision,
  input  logic [ADDRWIDTH-1:0] address_a,
  input  logic [ADDRWIDTH-1:0] address_b,
  input  logic [DATAWIDTH-1:0] data_a,
  input  logic [DATAWIDTH-1:0] data_b,
  input  logic                 wren_a,
  input  logic                 wren_b,
  input  logic [LANES-1:0]     be_a,
  input  logic [LANES-1:0]     be_b,
  output logic [DATAWIDTH-1:0] q_a,
  output logic [DATAWIDTH-1:0] q_b
);

  localparam int DEPTH    = 2 ** ADDRWIDTH;
  localparam bit DO_CLEAR = (CLEAR_ON_RESET != 0) && (MEM_INIT_FILE == "");

  if ((DATAWIDTH % BYTEWIDTH) != 0) begin : g_width_check
    $error("dpram_be: DATAWIDTH must be a multiple of BYTEWIDTH");
  end

  logic                 clr_en;
  logic [ADDRWIDTH-1:0] clr_addr;

  dpram_clear_ctl #(
    .ADDRWIDTH (ADDRWIDTH),
    .DO_CLEAR  (DO_CLEAR)
  ) u_clear_ctl (
    .clock_i    (clock),
    .reset_i    (reset),
    .ready_o    (ready),
    .clr_en_o   (clr_en),
    .clr_addr_o (clr_addr)
  );

  // User requests are ignored until the clear sweep has finished.
  logic req_a, req_b, same_addr;
  assign req_a     = ready & wren_a;
  assign req_b     = ready & wren_b;
  assign same_addr = (address_a == address_b);

  // The sequencer borrows port A's write path.
  logic [ADDRWIDTH-1:0] wr_addr_a;
  logic [DATAWIDTH-1:0] wr_data_a;
  assign wr_addr_a = clr_en ? clr_addr : address_a;
  assign wr_data_a = clr_en ? '0 : data_a;

  logic [LANES-1:0]     lane_we_a, lane_we_b;
  logic [DATAWIDTH-1:0] old_a, old_b, merged_a, merged_b;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [BYTEWIDTH-1:0] mem [DEPTH];

    assign lane_we_a[gi] = clr_en | (req_a & be_a[gi]);
    // On a shared lane at the same address port A wins, so B is masked.
    assign lane_we_b[gi] = req_b & be_b[gi] & ~(req_a & be_a[gi] & same_addr);

    always_ff @(posedge clock) begin
      if (lane_we_a[gi]) mem[wr_addr_a] <= wr_data_a[gi*BYTEWIDTH +: BYTEWIDTH];
      if (lane_we_b[gi]) mem[address_b] <= data_b[gi*BYTEWIDTH +: BYTEWIDTH];
    end

    // Array reads return the pre-edge word, giving old data cross-port.
    assign old_a[gi*BYTEWIDTH +: BYTEWIDTH] = mem[address_a];
    assign old_b[gi*BYTEWIDTH +: BYTEWIDTH] = mem[address_b];

    assign merged_a[gi*BYTEWIDTH +: BYTEWIDTH] = lane_we_a[gi] ?
        data_a[gi*BYTEWIDTH +: BYTEWIDTH] : old_a[gi*BYTEWIDTH +: BYTEWIDTH];
    assign merged_b[gi*BYTEWIDTH +: BYTEWIDTH] = lane_we_b[gi] ?
        data_b[gi*BYTEWIDTH +: BYTEWIDTH] : old_b[gi*BYTEWIDTH +: BYTEWIDTH];
  end

  logic [DATAWIDTH-1:0] q_a_q, q_a_d, q_b_q, q_b_d;
  logic [DATAWIDTH-1:0] qr_a_q, qr_b_q;
  logic                 collision_q, collision_d;

  always_comb begin
    q_a_d = '0;
    q_b_d = '0;
    if (ready) begin
      if (RDW_MODE == RDW_NO_CHANGE && req_a)  q_a_d = q_a_q;
      else if (RDW_MODE == RDW_WRITE_FIRST)    q_a_d = merged_a;
      else                                     q_a_d = old_a;

      if (RDW_MODE == RDW_NO_CHANGE && req_b)  q_b_d = q_b_q;
      else if (RDW_MODE == RDW_WRITE_FIRST)    q_b_d = merged_b;
      else                                     q_b_d = old_b;
    end
  end

  assign collision_d = req_a & req_b & same_addr & (|(be_a & be_b));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_a_q       <= '0;
      q_b_q       <= '0;
      qr_a_q      <= '0;
      qr_b_q      <= '0;
      collision_q <= 1'b0;
    end else begin
      q_a_q       <= q_a_d;
      q_b_q       <= q_b_d;
      // The extra stage runs every cycle, re-registering any held value.
      qr_a_q      <= q_a_q;
      qr_b_q      <= q_b_q;
      collision_q <= collision_d;
    end
  end

  assign q_a       = (OUT_REG != 0) ? qr_a_q : q_a_q;
  assign q_b       = (OUT_REG != 0) ? qr_b_q : q_b_q;
  assign collision = collision_q;

endmodule
